// File: rtl/soomrv_mem_pkg.sv
// Shared types for the data-SRAM arbitration path: Wishbone window, read owner and
// management FSM states.
package soomrv_mem_pkg;

  localparam logic [3:0] DSRAM_WIN = 4'h1;

  typedef enum logic {
    OWN_CORE,
    OWN_MGMT
  } owner_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRdWait,
    StAck
  } mgmt_state_e;

endpackage

// File: rtl/dsram_rd_capture.sv
// Owner pipeline for reads issued to the SRAM macro; steers the returned word into the
// capture register of whichever requester issued the read.
module dsram_rd_capture
  import soomrv_mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_i,
  input  owner_e      owner_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] core_rdata_o,
  output logic [31:0] mgmt_rdata_o,
  output logic        mgmt_done_o
);

  logic        s1_valid_q, s2_valid_q;
  owner_e      s1_owner_q, s2_owner_q;
  logic [31:0] core_rdata_q, mgmt_rdata_q;

  // Stage 1 marks the cycle in which macro data is valid; stage 2 tells the FSM
  // that the management capture register is now loaded.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_owner_q   <= OWN_CORE;
      s2_valid_q   <= 1'b0;
      s2_owner_q   <= OWN_CORE;
      core_rdata_q <= '0;
      mgmt_rdata_q <= '0;
    end else begin
      s1_valid_q <= issue_i;
      s1_owner_q <= owner_i;
      s2_valid_q <= s1_valid_q;
      s2_owner_q <= s1_owner_q;
      if (s1_valid_q && (s1_owner_q == OWN_CORE)) core_rdata_q <= mem_rdata_i;
      if (s1_valid_q && (s1_owner_q == OWN_MGMT)) mgmt_rdata_q <= mem_rdata_i;
    end
  end

  assign core_rdata_o = core_rdata_q;
  assign mgmt_rdata_o = mgmt_rdata_q;
  assign mgmt_done_o  = s2_valid_q && (s2_owner_q == OWN_MGMT);

endmodule

// File: rtl/dsram_arbiter.sv
// Run-time arbiter sharing the single-port data SRAM between the core (fixed priority)
// and the Wishbone management port, with a starvation bound on management latency.
module dsram_arbiter
  import soomrv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              core_ce_n,
  input  logic              core_we_n,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_wm,
  output logic              core_stall,
  output logic [31:0]       core_rdata,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_dataOut,
  output logic [3:0]        mem_wm,
  input  logic [31:0]       mem_dataIn
);

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  mgmt_state_e state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        mgmt_pend, mgmt_grant, core_grant, wb_req;
  logic        rd_issue, mgmt_rd_done;
  owner_e      rd_owner;
  logic [31:0] mgmt_rdata;
  logic        unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:20], wbs_adr_i[15:ADDR_W+2], wbs_adr_i[1:0]};

  assign wb_req    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[19:16] == DSRAM_WIN) && !ack_q;
  assign mgmt_pend = (state_q == StIssue);

  // Grants are gated by reset so the macro stays deselected while reset is held.
  assign mgmt_grant = wb_rst_ni && mgmt_pend && (core_ce_n || (starve_q == StarveMax));
  assign core_grant = wb_rst_ni && !core_ce_n && !mgmt_grant;
  assign core_stall = !core_ce_n && mgmt_grant;

  always_comb begin
    mem_ce      = 1'b1;
    mem_we      = 1'b1;
    mem_addr    = '0;
    mem_dataOut = '0;
    mem_wm      = '0;
    if (mgmt_grant) begin
      mem_ce      = 1'b0;
      mem_we      = !wbs_we_i;
      mem_addr    = wbs_adr_i[ADDR_W+1:2];
      mem_dataOut = wbs_dat_i;
      mem_wm      = wbs_sel_i;
    end else if (core_grant) begin
      mem_ce      = 1'b0;
      mem_we      = core_we_n;
      mem_addr    = core_addr;
      mem_dataOut = core_wdata;
      mem_wm      = core_wm;
    end
  end

  assign rd_issue = (mgmt_grant && !wbs_we_i) || (core_grant && core_we_n);
  assign rd_owner = mgmt_grant ? OWN_MGMT : OWN_CORE;

  always_comb begin
    starve_d = starve_q;
    if (mgmt_grant) begin
      starve_d = '0;
    end else if (mgmt_pend && (starve_q != StarveMax)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (wb_req) state_d = StIssue;
      end
      StIssue: begin
        if (mgmt_grant) begin
          state_d = wbs_we_i ? StAck : StRdWait;
          ack_d   = wbs_we_i;
        end
      end
      StRdWait: begin
        if (mgmt_rd_done) begin
          state_d = StAck;
          ack_d   = 1'b1;
          dat_d   = mgmt_rdata;
        end
      end
      StAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= StIdle;
      starve_q <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  dsram_rd_capture u_rd_capture (
    .clk_i        (wb_clk_i),
    .rst_ni       (wb_rst_ni),
    .issue_i      (rd_issue),
    .owner_i      (rd_owner),
    .mem_rdata_i  (mem_dataIn),
    .core_rdata_o (core_rdata),
    .mgmt_rdata_o (mgmt_rdata),
    .mgmt_done_o  (mgmt_rd_done)
  );

endmodule

// File: tb/tb_dsram_arbiter.sv
// Scoreboard bench for dsram_arbiter with a behavioural single-port SRAM macro model.
module tb_dsram_arbiter;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_ce_n, core_we_n, core_stall;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata, core_rdata;
  logic [3:0]    core_wm;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dataOut, mem_dataIn;
  logic [3:0]    mem_wm;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } exp_t;

  exp_t core_q[$];
  exp_t mgmt_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  dsram_arbiter #(.ADDR_W(AW), .STARVE_MAX(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .core_ce_n   (core_ce_n),
    .core_we_n   (core_we_n),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_wm     (core_wm),
    .core_stall  (core_stall),
    .core_rdata  (core_rdata),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .mem_ce      (mem_ce),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_dataOut (mem_dataOut),
    .mem_wm      (mem_wm),
    .mem_dataIn  (mem_dataIn)
  );

  // Macro model: latches on the rising edge, drives read data after the falling edge.
  logic [31:0]   mem [512];
  logic [AW-1:0] raddr_q = '0;

  always @(posedge clk) begin
    if (!mem_ce) begin
      if (!mem_we) begin
        logic [31:0] merged;
        merged = mem[mem_addr];
        for (int b = 0; b < 4; b++) if (mem_wm[b]) merged[8*b +: 8] = mem_dataOut[8*b +: 8];
        mem[mem_addr] <= merged;
      end else begin
        raddr_q <= mem_addr;
      end
    end
  end

  always @(negedge clk) mem_dataIn <= mem[raddr_q];

  // Monitor: pops expected responses whenever the DUT presents them.
  always @(negedge clk) begin
    if (wbs_ack_o) begin
      n_cmp++;
      if (mgmt_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ack: got ack with dat %h at cycle %0d, want no ack",
                 wbs_dat_o, cyc_cnt);
      end else begin
        exp_t e;
        e = mgmt_q.pop_front();
        if (wbs_dat_o !== e.dat || cyc_cnt != e.cyc) begin
          n_err++;
          $display("FAIL mgmt_ack: got dat %h at cycle %0d, want dat %h at cycle %0d",
                   wbs_dat_o, cyc_cnt, e.dat, e.cyc);
        end
      end
    end
    while (core_q.size() != 0 && core_q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = core_q.pop_front();
      n_cmp++;
      if (core_rdata !== e.dat) begin
        n_err++;
        $display("FAIL core_rdata: got %h at cycle %0d, want %h", core_rdata, cyc_cnt, e.dat);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic wb_drive(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
  endtask

  task automatic wb_drop();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  // Full management read with an idle core: request at k, grant k+1, ack k+4.
  task automatic mgmt_read(input logic [31:0] adr, input logic [31:0] exp);
    wb_drive(adr, 1'b0, 32'h0, 4'hF);
    mgmt_q.push_back('{cyc_cnt + 4, exp});
    repeat (5) next();
    wb_drop();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((core_q.size() != 0 || mgmt_q.size() != 0) && n < budget) begin
      next();
      n++;
    end
    if (core_q.size() != 0 || mgmt_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d core / %0d mgmt pending, want 0 / 0",
               core_q.size(), mgmt_q.size());
      core_q.delete();
      mgmt_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int k;
    int stalls;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[4]  = 32'hAAAA_BBBB;
    mem[5]  = 32'hDEAD_BEEF;
    mem[7]  = 32'hCAFE_F00D;
    mem[9]  = 32'h1111_2222;
    mem[32] = 32'hA5A5_0001;
    core_ce_n  = 1'b0;
    core_we_n  = 1'b1;
    core_addr  = 9'd5;
    core_wdata = '0;
    core_wm    = '0;
    wbs_adr_i  = '0;
    wbs_dat_i  = '0;
    wbs_sel_i  = '0;
    wb_drop();

    // Reset held with the core requesting: macro must stay deselected.
    next();
    @(negedge clk);
    chk("rst_mem_ce", 32'(mem_ce), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd1);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_wbs_dat", wbs_dat_o, 32'h0);
    chk("rst_core_rdata", core_rdata, 32'h0);
    next();
    rst_n     = 1'b1;
    core_ce_n = 1'b1;
    next();

    // Core read of 0x005.
    core_ce_n = 1'b0;
    core_we_n = 1'b1;
    core_addr = 9'h005;
    core_q.push_back('{cyc_cnt + 2, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("core_rd_stall", 32'(core_stall), 32'd0);
    chk("core_rd_ce", 32'(mem_ce), 32'd0);
    chk("core_rd_addr", 32'(mem_addr), 32'h5);
    next();
    core_ce_n = 1'b1;
    repeat (3) next();
    @(negedge clk);
    chk("core_rdata_hold", core_rdata, 32'hDEAD_BEEF);

    // Management write, core idle.
    next();
    k = cyc_cnt;
    wb_drive(32'h3001_0010, 1'b1, 32'h1234_5678, 4'b0011);
    mgmt_q.push_back('{k + 2, 32'h0});
    @(negedge clk);
    chk("wr_not_yet", 32'(mem_ce), 32'd1);
    next();
    @(negedge clk);
    chk("wr_ce", 32'(mem_ce), 32'd0);
    chk("wr_we", 32'(mem_we), 32'd0);
    chk("wr_addr", 32'(mem_addr), 32'h4);
    chk("wr_wm", 32'(mem_wm), 32'h3);
    chk("wr_data", mem_dataOut, 32'h1234_5678);
    next();
    next();
    wb_drop();
    drain(10);

    // Back-to-back core write then read, no bubble.
    next();
    core_ce_n  = 1'b0;
    core_we_n  = 1'b0;
    core_addr  = 9'h030;
    core_wdata = 32'h8765_4321;
    core_wm    = 4'b1100;
    @(negedge clk);
    chk("b2b_wr_ce", 32'(mem_ce), 32'd0);
    next();
    core_we_n = 1'b1;
    core_q.push_back('{cyc_cnt + 2, 32'h8765_0000});
    @(negedge clk);
    chk("b2b_rd_ce", 32'(mem_ce), 32'd0);
    chk("b2b_rd_stall", 32'(core_stall), 32'd0);
    next();
    core_ce_n = 1'b1;
    drain(10);

    // Starvation: core reads every cycle while management reads word 0x20.
    next();
    k = cyc_cnt;
    stalls = 0;
    core_ce_n = 1'b0;
    core_we_n = 1'b1;
    core_addr = 9'h007;
    wb_drive(32'h3001_0080, 1'b0, 32'h0, 4'hF);
    mgmt_q.push_back('{k + 12, 32'hA5A5_0001});
    for (int i = 0; i < 15; i++) begin
      if (i == 13) wb_drop();
      @(negedge clk);
      if (core_stall) stalls++;
      chk("starve_addr", 32'(mem_addr), (i == 9) ? 32'h20 : 32'h7);
      if (i != 9) core_q.push_back('{cyc_cnt + 2, 32'hCAFE_F00D});
      next();
    end
    core_ce_n = 1'b1;
    chk("starve_stall_count", 32'(stalls), 32'd1);
    drain(10);

    // Interleave: management read granted, core read the cycle after.
    next();
    k = cyc_cnt;
    wb_drive(32'h3001_0024, 1'b0, 32'h0, 4'hF);
    mgmt_q.push_back('{k + 4, 32'h1111_2222});
    next();
    @(negedge clk);
    chk("il_mgmt_addr", 32'(mem_addr), 32'h9);
    next();
    core_ce_n = 1'b0;
    core_addr = 9'h005;
    core_q.push_back('{k + 4, 32'hDEAD_BEEF});
    next();
    core_ce_n = 1'b1;
    next();
    next();
    wb_drop();
    drain(10);

    // Read back the masked write from earlier.
    next();
    mgmt_read(32'h3001_0010, 32'hAAAA_5678);
    drain(10);

    // Reset during RD_WAIT drops the in-flight read.
    next();
    wb_drive(32'h3001_0024, 1'b0, 32'h0, 4'hF);
    next();
    next();
    rst_n = 1'b0;
    wb_drop();
    @(negedge clk);
    chk("rdwait_rst_ce", 32'(mem_ce), 32'd1);
    next();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rdwait_rst_ack", 32'(wbs_ack_o), 32'd0);
      chk("rdwait_rst_dat", wbs_dat_o, 32'h0);
      next();
    end
    chk("rdwait_rst_core_rdata", core_rdata, 32'h0);
    mgmt_read(32'h3001_0014, 32'hDEAD_BEEF);
    drain(10);

    // Out-of-window request is ignored.
    next();
    wb_drive(32'h3002_0000, 1'b0, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("oow_ce", 32'(mem_ce), 32'd1);
      chk("oow_ack", 32'(wbs_ack_o), 32'd0);
      next();
    end
    wb_drop();
    repeat (4) next();
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
